// File: rtl/sram_req_master_if.sv
// -----------------------------------------------------------------------------
// sram_req_master_if
// Purpose : bundles the LSU request/response handshake and the SRAM port of
//           sram_req_master into one interface.
// Signals :
//   req_valid/req_ready/req_wr/req_size/req_unsigned/req_addr/req_wdata
//       LSU -> master request channel
//   resp_valid/resp_ready/resp_rdata/resp_err
//       master -> LSU response channel
//   sram_req/sram_wr/sram_addr/sram_wdata/sram_wmask/sram_rdata
//       master <-> SRAM access port
// Modports:
//   master : the sram_req_master block (initiator toward the SRAM)
//   slave  : the surroundings (LSU driving requests, SRAM returning data)
//
// Handshake semantics (both req and resp channels): a transfer happens on a
// rising clock edge where valid && ready are both 1. Once valid is raised by
// the producer it stays high with stable payload until that transfer edge;
// ready may be raised or lowered freely and never depends on a future valid.
// -----------------------------------------------------------------------------
interface sram_req_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        sram_req;
    logic        sram_wr;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [7:0]  sram_wmask;
    logic [31:0] sram_rdata;

    modport master (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output sram_req, sram_wr, sram_addr, sram_wdata, sram_wmask,
        input  sram_rdata
    );

    modport slave (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  sram_req, sram_wr, sram_addr, sram_wdata, sram_wmask,
        output sram_rdata
    );
endinterface

// File: rtl/sram_req_master.sv
// -----------------------------------------------------------------------------
// sram_req_master
// Purpose : turns one LSU load/store into one word-aligned SRAM access with a
//           byte-lane write mask, then returns sign/zero-extended load data or
//           a store ack. Misaligned or reserved-size requests are answered
//           with resp_err and never reach the SRAM. One request outstanding.
// Parameters:
//   RD_LAT : cycles from the edge that samples sram_req to valid sram_rdata (>=1)
//   CNT_W  : width of the read-latency counter (2**CNT_W > RD_LAT)
// Ports   :
//   clock        in   single clock, all logic on posedge
//   resetn       in   synchronous active-low reset
//   bus          if   sram_req_master_if.master (request, response, SRAM port)
//   o_dbg_state  out  current FSM state (0=IDLE 1=ISSUE 2=WAIT 3=RESP)
// -----------------------------------------------------------------------------
module sram_req_master #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    sram_req_master_if.master         bus,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // State and latched request fields
    state_t             r_state;
    logic               r_wr;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [1:0]         r_lane;
    logic [CNT_W-1:0]   r_cnt;

    // Registered outputs
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [31:0]        r_resp_rdata;
    logic               r_sram_req;
    logic               r_sram_wr;
    logic [31:0]        r_sram_addr;
    logic [31:0]        r_sram_wdata;
    logic [3:0]         r_sram_wmask;

    // Next-state values
    state_t             w_state_nxt;
    logic               w_wr_nxt;
    logic [1:0]         w_size_nxt;
    logic               w_unsigned_nxt;
    logic [1:0]         w_lane_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_resp_valid_nxt;
    logic               w_resp_err_nxt;
    logic [31:0]        w_resp_rdata_nxt;
    logic               w_sram_req_nxt;
    logic               w_sram_wr_nxt;
    logic [31:0]        w_sram_addr_nxt;
    logic [31:0]        w_sram_wdata_nxt;
    logic [3:0]         w_sram_wmask_nxt;

    // Request decode (only meaningful while IDLE)
    logic               w_misalign;
    logic [3:0]         w_lane_mask;
    logic [31:0]        w_wdata_sh;

    // Load data extraction from the returned word
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;
    logic [31:0]        w_rd_ext;

    // Size 3 is reserved and treated exactly like a misaligned access.
    assign w_misalign = (bus.req_size == 2'd3) ||
                        ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        w_lane_mask = 4'b1111;
        case (bus.req_size)
            2'd0:    w_lane_mask = 4'b0001 << bus.req_addr[1:0];
            2'd1:    w_lane_mask = 4'b0011 << bus.req_addr[1:0];
            default: w_lane_mask = 4'b1111;
        endcase
    end

    // Store data arrives right-aligned; move it onto its byte lane.
    assign w_wdata_sh = bus.req_wdata << {bus.req_addr[1:0], 3'b000};

    assign w_rd_byte = 8'(bus.sram_rdata >> {r_lane, 3'b000});
    assign w_rd_half = r_lane[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];

    always_comb begin
        w_rd_ext = bus.sram_rdata;
        case (r_size)
            2'd0:    w_rd_ext = {{24{~r_unsigned & w_rd_byte[7]}}, w_rd_byte};
            2'd1:    w_rd_ext = {{16{~r_unsigned & w_rd_half[15]}}, w_rd_half};
            default: w_rd_ext = bus.sram_rdata;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_nxt         = r_wr;
        w_size_nxt       = r_size;
        w_unsigned_nxt   = r_unsigned;
        w_lane_nxt       = r_lane;
        w_cnt_nxt        = r_cnt;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_err_nxt   = r_resp_err;
        w_resp_rdata_nxt = r_resp_rdata;
        // The SRAM strobe is a one-cycle pulse: low unless raised below.
        w_sram_req_nxt   = 1'b0;
        w_sram_wr_nxt    = 1'b0;
        w_sram_addr_nxt  = r_sram_addr;
        w_sram_wdata_nxt = r_sram_wdata;
        w_sram_wmask_nxt = r_sram_wmask;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_wr_nxt       = bus.req_wr;
                    w_size_nxt     = bus.req_size;
                    w_unsigned_nxt = bus.req_unsigned;
                    w_lane_nxt     = bus.req_addr[1:0];
                    if (w_misalign) begin
                        w_state_nxt      = S_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_rdata_nxt = 32'd0;
                    end else begin
                        w_state_nxt      = S_ISSUE;
                        w_sram_req_nxt   = 1'b1;
                        w_sram_wr_nxt    = bus.req_wr;
                        w_sram_addr_nxt  = {bus.req_addr[31:2], 2'b00};
                        w_sram_wdata_nxt = w_wdata_sh;
                        w_sram_wmask_nxt = bus.req_wr ? w_lane_mask : 4'b0000;
                    end
                end
            end
            S_ISSUE: begin
                // The SRAM samples the strobe at this edge; a store is done.
                if (r_wr) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = 32'd0;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt      = S_RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = w_rd_ext;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = 32'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset aborts any access in flight: no response is ever produced for it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'd0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_sram_req   <= 1'b0;
            r_sram_wr    <= 1'b0;
            r_sram_addr  <= 32'd0;
            r_sram_wdata <= 32'd0;
            r_sram_wmask <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr         <= w_wr_nxt;
            r_size       <= w_size_nxt;
            r_unsigned   <= w_unsigned_nxt;
            r_lane       <= w_lane_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_sram_req   <= w_sram_req_nxt;
            r_sram_wr    <= w_sram_wr_nxt;
            r_sram_addr  <= w_sram_addr_nxt;
            r_sram_wdata <= w_sram_wdata_nxt;
            r_sram_wmask <= w_sram_wmask_nxt;
        end
    end

    // Ready is held low through the reset cycle even if the state is IDLE.
    assign bus.req_ready  = (r_state == S_IDLE) && resetn;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.sram_req   = r_sram_req;
    assign bus.sram_wr    = r_sram_wr;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign bus.sram_wmask = {4'b0000, r_sram_wmask};
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sram_req_master.sv
// -----------------------------------------------------------------------------
// tb_sram_req_master
// Bench for sram_req_master with a behavioural SRAM of read latency RD_LAT.
// Table-driven load/store vectors plus hand-written sequences for response
// back-pressure and reset during an in-flight load.
// -----------------------------------------------------------------------------
module tb_sram_req_master;

    localparam int RD_LAT = 3;
    localparam int LL     = 2 + RD_LAT;   // load accept -> resp_valid cycles

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nreq;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] dbg_state;

    always #5 clock = ~clock;

    sram_req_master_if bus ();

    sram_req_master #(.RD_LAT(RD_LAT), .CNT_W(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] mem [0:63];
    logic [31:0] pipe [RD_LAT];
    logic        pv   [RD_LAT];
    int          sram_req_cnt = 0;
    logic        last_wr;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [7:0]  last_wmask;

    always @(posedge clock) begin
        pv[0]   <= bus.sram_req && !bus.sram_wr;
        pipe[0] <= mem[bus.sram_addr[7:2]];
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k]   <= pv[k-1];
            pipe[k] <= pipe[k-1];
        end
        if (bus.sram_req) begin
            sram_req_cnt <= sram_req_cnt + 1;
            last_wr      <= bus.sram_wr;
            last_addr    <= bus.sram_addr;
            last_wdata   <= bus.sram_wdata;
            last_wmask   <= bus.sram_wmask;
            if (bus.sram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wmask[b])
                        mem[bus.sram_addr[7:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end
        end
    end

    // Junk outside the valid cycle exposes an off-by-one capture.
    assign bus.sram_rdata = pv[RD_LAT-1] ? pipe[RD_LAT-1] : 32'hBADBAD00;

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];   // {err, rdata}
    int          total = 0;
    int          bad   = 0;
    int          nreq_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_nreq,
                                input logic [31:0] exp_wdata, input logic [7:0] exp_wmask);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_nreq = exp_nreq; v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input vec_t v);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_wr       = v.wr;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        nreq_base = sram_req_cnt;
        @(posedge clock);
        @(negedge clock);
        // Scramble the fields: the DUT must use what it latched.
        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic wait_resp(input vec_t v, input int hold);
        int          lat;
        logic [32:0] e;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("latency", lat, v.exp_lat);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                bus.req_valid    = 1'b1;
                bus.req_wr       = 1'b1;
                bus.req_size     = 2'd2;
                bus.req_addr     = 32'h8000_0004;
                bus.req_wdata    = 32'hFFFF_FFFF;
                @(negedge clock);
                chk("hold_valid", 32'(bus.resp_valid), 32'd1);
                chk("hold_rdata", bus.resp_rdata, v.exp_rdata);
                chk("hold_ready", 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid  = 1'b0;
            bus.resp_ready = 1'b1;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata, e[31:0]);
            chk("resp_err", 32'(bus.resp_err), 32'(e[32]));
        end else begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end
        @(negedge clock);
        chk("resp_clear", 32'(bus.resp_valid), 32'd0);
        chk("sram_req_count", sram_req_cnt - nreq_base, v.exp_nreq);
        if (v.exp_nreq > 0) begin
            chk("sram_addr", last_addr, {v.addr[31:2], 2'b00});
            chk("sram_wr", 32'(last_wr), 32'(v.wr));
            chk("sram_wmask", 32'(last_wmask), 32'(v.exp_wmask));
            if (v.wr) chk("sram_wdata", last_wdata, v.exp_wdata);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},      32'(dbg_state),       32'd0);
        chk({tag, "_req_ready"},  32'(bus.req_ready),   32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid),  32'd0);
        chk({tag, "_resp_err"},   32'(bus.resp_err),    32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata,       32'd0);
        chk({tag, "_sram_req"},   32'(bus.sram_req),    32'd0);
        chk({tag, "_sram_wr"},    32'(bus.sram_wr),     32'd0);
        chk({tag, "_sram_addr"},  bus.sram_addr,        32'd0);
        chk({tag, "_sram_wdata"}, bus.sram_wdata,       32'd0);
        chk({tag, "_sram_wmask"}, 32'(bus.sram_wmask),  32'd0);
    endtask

    // ---------------- test ----------------
    vec_t vecs [21];

    initial begin
        vec_t vh, vl, vl2;
        logic seen;

        vecs[0]  = mk(1, 2, 0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 0, 2,  1, 32'hDEAD_BEEF, 8'h0F);
        vecs[1]  = mk(0, 2, 0, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0, LL, 1, 32'h0,         8'h00);
        vecs[2]  = mk(1, 2, 0, 32'h8000_0000, 32'h0,         32'h0000_0000, 0, 2,  1, 32'h0,         8'h0F);
        vecs[3]  = mk(1, 0, 0, 32'h8000_0003, 32'h0000_00A5, 32'h0000_0000, 0, 2,  1, 32'hA500_0000, 8'h08);
        vecs[4]  = mk(0, 0, 0, 32'h8000_0003, 32'h0,         32'hFFFF_FFA5, 0, LL, 1, 32'h0,         8'h00);
        vecs[5]  = mk(0, 0, 1, 32'h8000_0003, 32'h0,         32'h0000_00A5, 0, LL, 1, 32'h0,         8'h00);
        vecs[6]  = mk(1, 2, 0, 32'h8000_0000, 32'h8001_7F00, 32'h0000_0000, 0, 2,  1, 32'h8001_7F00, 8'h0F);
        vecs[7]  = mk(0, 1, 0, 32'h8000_0002, 32'h0,         32'hFFFF_8001, 0, LL, 1, 32'h0,         8'h00);
        vecs[8]  = mk(0, 1, 1, 32'h8000_0002, 32'h0,         32'h0000_8001, 0, LL, 1, 32'h0,         8'h00);
        vecs[9]  = mk(0, 1, 0, 32'h8000_0000, 32'h0,         32'h0000_7F00, 0, LL, 1, 32'h0,         8'h00);
        vecs[10] = mk(0, 0, 0, 32'h8000_0001, 32'h0,         32'h0000_007F, 0, LL, 1, 32'h0,         8'h00);
        vecs[11] = mk(1, 1, 0, 32'h8000_0006, 32'h0000_1234, 32'h0000_0000, 0, 2,  1, 32'h1234_0000, 8'h0C);
        vecs[12] = mk(0, 2, 0, 32'h8000_0004, 32'h0,         32'h1234_BEEF, 0, LL, 1, 32'h0,         8'h00);
        vecs[13] = mk(0, 0, 0, 32'h8000_0005, 32'h0,         32'hFFFF_FFBE, 0, LL, 1, 32'h0,         8'h00);
        vecs[14] = mk(0, 2, 0, 32'h8000_0002, 32'h0,         32'h0000_0000, 1, 1,  0, 32'h0,         8'h00);
        vecs[15] = mk(1, 1, 0, 32'h8000_0001, 32'h0000_5555, 32'h0000_0000, 1, 1,  0, 32'h0,         8'h00);
        vecs[16] = mk(0, 3, 0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1, 1,  0, 32'h0,         8'h00);
        vecs[17] = mk(1, 0, 0, 32'h8000_0002, 32'h1122_3344, 32'h0000_0000, 0, 2,  1, 32'h3344_0000, 8'h04);
        vecs[18] = mk(0, 2, 1, 32'h8000_0000, 32'h0,         32'h8044_7F00, 0, LL, 1, 32'h0,         8'h00);
        vecs[19] = mk(1, 2, 1, 32'h8000_0008, 32'hCAFE_F00D, 32'h0000_0000, 0, 2,  1, 32'hCAFE_F00D, 8'h0F);
        vecs[20] = mk(1, 3, 0, 32'h8000_0004, 32'h7777_7777, 32'h0000_0000, 1, 1,  0, 32'h0,         8'h00);

        vh  = mk(0, 2, 0, 32'h8000_0004, 32'h0, 32'h1234_BEEF, 0, LL, 1, 32'h0, 8'h00);
        vl  = mk(0, 2, 0, 32'h8000_0004, 32'h0, 32'h1234_BEEF, 0, LL, 1, 32'h0, 8'h00);
        vl2 = mk(0, 2, 0, 32'h8000_0000, 32'h0, 32'h8044_7F00, 0, LL, 1, 32'h0, 8'h00);

        resetn           = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_wr       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b1;

        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        resetn = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // Table-driven loads/stores/errors
        for (int i = 0; i < 21; i++) begin
            drive_req(vecs[i]);
            wait_resp(vecs[i], 0);
        end

        // Response back-pressure: 4 cycles of resp_ready=0 with a competing request
        bus.resp_ready = 1'b0;
        drive_req(vh);
        wait_resp(vh, 4);
        // The ignored store must not have reached memory.
        drive_req(vh);
        wait_resp(vh, 0);

        // Reset while a load sits in WAIT
        drive_req(vl);
        @(negedge clock);
        chk("dbg_wait", 32'(dbg_state), 32'd2);
        resetn = 1'b0;
        @(negedge clock);
        check_reset_vals("abort");
        resetn = 1'b1;
        exp_q.delete();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (bus.resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_abort", 32'(seen), 32'd0);
        chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
        drive_req(vl2);
        wait_resp(vl2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
